// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: NOP encoding, fetch FSM states, default datapath width.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Purpose: three 32-bit saturating event counters for the fetch unit (present only with IFU_PERF_CNT_EN).
// Latency: an increment strobe is visible on the output the cycle after it is seen.
// Backpressure: none; counters hold at all-ones instead of wrapping.
`ifdef IFU_PERF_CNT_EN
module ifu_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    input  logic        flush_inc_i,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
);

    logic [31:0] fetch_q, fetch_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        fetch_d = fetch_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (fetch_inc_i && (fetch_q != '1)) fetch_d = fetch_q + 32'd1;
        if (stall_inc_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (flush_inc_i && (flush_q != '1)) flush_d = flush_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign perf_fetch_o = fetch_q;
    assign perf_stall_o = stall_q;
    assign perf_flush_o = flush_q;

endmodule
`endif

// File: rtl/ifu_fetch_ctrl.sv
// Purpose: PC, single-outstanding imem request port, 1-entry hold buffer and IF/ID register; optional perf counters via IFU_PERF_CNT_EN.
// Latency: request is combinational from state; an accepted response reaches IF/ID on the next edge (1 instr/cycle with 1-cycle imem).
// Backpressure: pc_wren/IFID_wren stalls park a returning response in the hold buffer; no new request while the hold is occupied.
module ifu_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pc_wren_i,
    input  logic            IFID_wren_i,
    input  logic            IFID_clear_i,
    input  logic            br_flush_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            IFID_valid_o,
    output logic [XLEN-1:0] IFID_pc_o,
    output logic [31:0]     IFID_instr_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_stall_o,
    output logic [31:0]     perf_flush_o
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_ent_t;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam fetch_ent_t      BUBBLE     = '{pc: '0, instr: RV_NOP};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            hold_vld_q, hold_vld_d;
    fetch_ent_t      hold_q, hold_d;
    logic            ifid_vld_q, ifid_vld_d;
    fetch_ent_t      ifid_q, ifid_d;

    logic [XLEN-1:0] pc_inc;
    logic            resp_acc;
    logic            resp_to_ifid;
    logic            hold_pop;
    logic            can_issue;

    assign pc_inc = pc_q + PC_STEP;

    // A response is only ours when a live request is outstanding and no redirect kills it.
    assign resp_acc     = (state_q == WAIT) & imem_rvalid_i & ~br_flush_i;
    assign resp_to_ifid = resp_acc & IFID_wren_i & ~hold_vld_q;
    assign hold_pop     = hold_vld_q & IFID_wren_i & ~IFID_clear_i;

    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (br_flush_i) begin
            hold_vld_d = 1'b0;
        end else begin
            if (hold_pop) hold_vld_d = 1'b0;
            if (resp_acc && !resp_to_ifid) begin
                hold_vld_d = 1'b1;
                hold_d     = '{pc: pc_q, instr: imem_rdata_i};
            end
        end
    end

    // Issue only if the hold will be free after this edge, so it can never overflow.
    assign can_issue = pc_wren_i & ~br_flush_i & ~hold_vld_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    imem_req_o = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (br_flush_i) begin
                        state_d = IDLE;
                    end else begin
                        pc_d = pc_inc;
                        if (can_issue) begin
                            imem_req_o  = 1'b1;
                            imem_addr_o = pc_inc;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (br_flush_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // Stale response retires the outstanding slot; a flush here keeps waiting for it.
                if (imem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (br_flush_i) pc_d = br_target_i & ALIGN_MASK;
    end

    always_comb begin
        ifid_vld_d = ifid_vld_q;
        ifid_d     = ifid_q;
        if (IFID_clear_i) begin
            ifid_vld_d = 1'b0;
            ifid_d     = BUBBLE;
        end else if (IFID_wren_i) begin
            if (hold_vld_q) begin
                ifid_vld_d = 1'b1;
                ifid_d     = hold_q;
            end else if (resp_to_ifid) begin
                ifid_vld_d = 1'b1;
                ifid_d     = '{pc: pc_q, instr: imem_rdata_i};
            end else begin
                ifid_vld_d = 1'b0;
                ifid_d     = BUBBLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            hold_vld_q <= 1'b0;
            hold_q     <= BUBBLE;
            ifid_vld_q <= 1'b0;
            ifid_q     <= BUBBLE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
            ifid_vld_q <= ifid_vld_d;
            ifid_q     <= ifid_d;
        end
    end

    assign IFID_valid_o = ifid_vld_q;
    assign IFID_pc_o    = ifid_q.pc;
    assign IFID_instr_o = ifid_q.instr;

`ifdef IFU_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = ~IFID_clear_i & IFID_wren_i & (hold_vld_q | resp_to_ifid);
    assign stall_inc = (state_q == WAIT) & ~imem_rvalid_i;

    ifu_perf_cnt u_perf_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .fetch_inc_i (fetch_inc),
        .stall_inc_i (stall_inc),
        .flush_inc_i (br_flush_i),
        .perf_fetch_o(perf_fetch_o),
        .perf_stall_o(perf_stall_o),
        .perf_flush_o(perf_flush_o)
    );
`endif

endmodule
